// File: rtl/dequant_zigzag_if.sv
// Coefficient stream and quant-table write port feeding dequant_zigzag.
// The master side is the entropy decoder / table loader, the slave side is the block.
interface dequant_zigzag_if;
    logic signed [11:0] coef_in;
    logic               coef_valid;
    logic               coef_last;
    logic               coef_ready;
    logic               qtab_we;
    logic [5:0]         qtab_addr;
    logic [7:0]         qtab_data;

    modport master (
        output coef_in, coef_valid, coef_last, qtab_we, qtab_addr, qtab_data,
        input  coef_ready
    );

    modport slave (
        input  coef_in, coef_valid, coef_last, qtab_we, qtab_addr, qtab_data,
        output coef_ready
    );
endinterface

// File: rtl/dequant_zigzag.sv
// Dequantises a zigzag-ordered coefficient stream into a natural-order 8x8 block,
// then hands the block to an IDCT through a start pulse / done level handshake.
module dequant_zigzag (
    input  logic                sys_clk,
    input  logic                sys_rst,
    dequant_zigzag_if.slave     bus,
    output logic signed [15:0]  x_out [0:7][0:7],
    output logic                idct_start,
    input  logic                idct_done,
    output logic                busy
);
    typedef enum logic [1:0] {CLEAR, FILL, START, WAIT} state_t;

    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t             state;
    state_t             state_next;
    logic [5:0]         k;
    logic [7:0]         qtab [64];
    logic               transfer;
    logic [7:0]         q;
    logic [5:0]         nat;
    logic signed [20:0] prod;
    logic signed [15:0] sat;

    assign transfer = bus.coef_valid && bus.coef_ready;
    assign q        = qtab[k];
    assign nat      = ZIGZAG[k];
    assign prod     = $signed({{9{bus.coef_in[11]}}, bus.coef_in}) * $signed({13'd0, q});

    always_comb begin
        if (prod > 21'sd32767) begin
            sat = 16'sh7fff;
        end else if (prod < -21'sd32768) begin
            sat = 16'sh8000;
        end else begin
            sat = prod[15:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.coef_ready = 1'b0;
        idct_start     = 1'b0;
        busy           = 1'b1;
        case (state)
            CLEAR: state_next = FILL;
            FILL: begin
                bus.coef_ready = 1'b1;
                busy           = 1'b0;
                if (transfer && (bus.coef_last || k == 6'd63)) begin
                    state_next = START;
                end
            end
            START: begin
                idct_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (idct_done) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // The multiply reads qtab[k] combinationally, so a same-edge table write
    // to that entry only affects later transfers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 64; i++) begin
                qtab[i] <= 8'd1;
            end
        end else if (bus.qtab_we) begin
            qtab[bus.qtab_addr] <= bus.qtab_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state == CLEAR) begin
            k <= '0;
        end else if (transfer) begin
            k <= k + 6'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state == CLEAR) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    x_out[r][c] <= '0;
                end
            end
        end else if (transfer) begin
            x_out[nat[5:3]][nat[2:0]] <= sat;
        end
    end
endmodule
